// File: rtl/simple_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simple_rr_arbiter
// Purpose  : N-requester round-robin arbiter with a registered one-hot grant.
//            Each cycle the first active request at or after the priority
//            pointer wins. The pointer then moves to the index just past the
//            winner, so every requester that holds its request is served
//            within N cycles.
// Ports    : clk    - rising-edge clock
//            rst    - synchronous reset, active low (asserted when 0)
//            req    - [N-1:0] request vector, bit i = requester i
//            grants - [N-1:0] registered one-hot grant, or all zeros
// Revision : 1.0 - initial release
// ============================================================================
module simple_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grants
);

  localparam int PW = (N > 2) ? $clog2(N) : 1;
  localparam logic [PW:0] c_n_ext = (PW + 1)'(N);
  localparam logic [PW-1:0] c_last = PW'(N - 1);

  logic [PW-1:0] r_ptr;
  logic [N-1:0]  r_grants;

  logic          w_found;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  // Search req in rotated order ptr, ptr+1, ..., wrapping modulo N.
  // One extra bit on the sum keeps ptr+k from overflowing before the wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (PW + 1)'(k);
      if (w_sum >= c_n_ext) begin
        w_sum = w_sum - c_n_ext;
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Pointer moves just past the winner; the last index wraps back to 0.
  // Non-power-of-two N needs the explicit wrap, so no reliance on overflow.
  always_comb begin
    if (w_win == c_last) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr    <= '0;
      r_grants <= '0;
    end else if (w_found) begin
      r_ptr    <= w_ptr_nxt;
      r_grants <= N'(1) << w_win;
    end else begin
      // No requesters: drop the grant but keep the rotation position.
      r_grants <= '0;
    end
  end

  assign grants = r_grants;

endmodule
`default_nettype wire

// File: tb/tb_simple_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_rr_arbiter
// Purpose  : Self-checking bench for simple_rr_arbiter (N = 8). Vector table
//            plus hand sequences and a random stretch against a reference
//            model; expected grants are queued when stimulus is driven and
//            popped when the registered output is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_rr_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grants;

  int n_checks;
  int n_fails;

  logic [N-1:0] sb_q[$];

  typedef struct {
    logic         rstv;
    logic [N-1:0] req;
    logic [N-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the random stretch.
  int m_ptr;

  simple_rr_arbiter #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .grants (grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue its expectation, sample after the edge.
  task automatic apply(input logic rstv, input logic [N-1:0] r,
                       input logic [N-1:0] e, input string name);
    logic [N-1:0] exp_v;
    @(negedge clk);
    rst = rstv;
    req = r;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    n_checks++;
    if (grants !== exp_v) begin
      n_fails++;
      $display("FAIL %s: grants=%b required=%b", name, grants, exp_v);
    end
  endtask

  function automatic logic [N-1:0] model_step(input logic rstv, input logic [N-1:0] r);
    logic [N-1:0] g;
    int idx;
    bit found;
    g = '0;
    found = 0;
    if (!rstv) begin
      m_ptr = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && r[idx]) begin
          found = 1;
          g[idx] = 1'b1;
          m_ptr = (idx + 1) % N;
        end
      end
    end
    return g;
  endfunction

  task automatic add(input logic rstv, input logic [N-1:0] r,
                     input logic [N-1:0] e, input string name);
    vec_t v;
    v.rstv = rstv; v.req = r; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [N-1:0] r;
    logic         rv;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    req = '0;

    // Reset, with req active to show it is ignored.
    add(1'b0, 8'b11111111, 8'b00000000, "reset_ignores_req");
    // Sequence one.
    add(1'b1, 8'b10011011, 8'b00000001, "seq1_0");
    add(1'b1, 8'b10011010, 8'b00000010, "seq1_1");
    add(1'b1, 8'b10011000, 8'b00001000, "seq1_2");
    add(1'b1, 8'b10011000, 8'b00010000, "seq1_3");
    add(1'b1, 8'b10001010, 8'b10000000, "seq1_4_wrap");
    add(1'b1, 8'b00001010, 8'b00000010, "seq1_5");
    // Sequence two.
    add(1'b0, 8'b00000000, 8'b00000000, "reset2");
    add(1'b1, 8'b10011010, 8'b00000010, "seq2_0");
    add(1'b1, 8'b10011000, 8'b00001000, "seq2_1");
    add(1'b1, 8'b10011000, 8'b00010000, "seq2_2");
    add(1'b1, 8'b10001010, 8'b10000000, "seq2_3");
    add(1'b1, 8'b00001010, 8'b00000010, "seq2_4");
    // Idle cycles keep the pointer: set ptr=3, idle, then check search origin.
    add(1'b0, 8'b00000000, 8'b00000000, "reset3");
    add(1'b1, 8'b00000100, 8'b00000100, "idle_setup_ptr3");
    add(1'b1, 8'b00000000, 8'b00000000, "idle_0");
    add(1'b1, 8'b00000000, 8'b00000000, "idle_1");
    add(1'b1, 8'b00000000, 8'b00000000, "idle_2");
    add(1'b1, 8'b00001001, 8'b00001000, "idle_ptr3_kept");
    add(1'b1, 8'b00000000, 8'b00000000, "idle_3");
    add(1'b1, 8'b00000011, 8'b00000001, "idle_ptr4_wraps_to_0");

    foreach (vecs[i]) begin
      apply(vecs[i].rstv, vecs[i].req, vecs[i].exp, vecs[i].name);
    end

    // All requesters held: strict rotation 0..7 then 0 again.
    apply(1'b0, 8'h00, 8'h00, "reset_rot");
    for (int i = 0; i < 9; i++) begin
      r = 8'b1 << (i % N);
      apply(1'b1, 8'hFF, r, $sformatf("rotate_%0d", i));
    end

    // Single requester keeps winning.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 8'b00100000, 8'b00100000, $sformatf("single_%0d", i));
    end

    // Mid-stream reset: reach ptr=5, reset with all requesting, then resume.
    apply(1'b0, 8'h00, 8'h00, "reset_mid_pre");
    apply(1'b1, 8'b00010000, 8'b00010000, "mid_setup_ptr5");
    apply(1'b0, 8'hFF, 8'h00, "mid_reset_clears");
    apply(1'b1, 8'hFF, 8'b00000001, "mid_after_reset_bit0");

    // Random stretch against the reference model, with occasional resets.
    apply(1'b0, 8'h00, 8'h00, "reset_rand");
    m_ptr = 0;
    for (int i = 0; i < 60; i++) begin
      rv = ($urandom_range(0, 19) != 0);
      r  = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
      apply(rv, r, model_step(rv, r), $sformatf("rand_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simple_rr_arbiter.md
# simple_rr_arbiter

Parameterised N-requester round-robin arbiter with a registered one-hot grant output. Each cycle it grants exactly one active requester, or none. Priority rotates so the requester after the last winner is searched first. It sits between N competing request sources and a single shared resource and guarantees starvation-free access.

## Interface

- Parameters
  - `N`, default 8: number of requesters; N ≥ 2.
- Ports
  - `clk`, input, 1: single clock; all state updates on its rising edge.
  - `rst`, input, 1: reset, synchronous and active-low; asserted when `rst` = 0.
  - `req`, input, N: request vector; bit i = requester i wants the resource this cycle.
  - `grants`, output, N: registered one-hot grant vector, or all zeros.

## Operation

- Internal state:
  - priority pointer `ptr`, width ceil(log2 N), range 0..N-1;
  - `grants` register.
- `ptr` names the highest-priority index. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, with wrap-around modulo N.
- Each rising edge, with `rst` = 1:
  - if `req` ≠ 0: let w = first set bit of `req` in search order;
    - `grants` ← one-hot(w);
    - `ptr` ← (w+1) mod N; when w = N-1, ptr wraps to 0.
  - if `req` = 0: `grants` ← 0; `ptr` unchanged.
- Exactly one `grants` bit is set whenever the sampled `req` was non-zero.
- A granted bit is always a bit that was set in the sampled `req`.
- No grant locking: the winner is recomputed every cycle. A requester holding `req` high does not keep the grant if others are waiting.
- Single active requester: granted every cycle it requests.
- Fairness: with all N bits held high, grants rotate 0,1,…,N-1,0,…. Every active requester is served within N cycles.
- Requests that drop are simply skipped. There is no memory of unserved requests.

## Timing

- Reset, sampled on the rising edge while `rst` = 0:
  - `grants` ← 0, `ptr` ← 0;
  - `req` is ignored during reset.
- Reset mid-operation: on the first reset edge, any outstanding grant is cleared and priority returns to bit 0.
- Latency is 1 cycle: `req` sampled at edge k determines `grants` after edge k, stable until edge k+1.
- `req` must be stable around the rising edge (setup/hold). No other handshake exists; there is no acknowledge input.
- First edge after reset deasserts: priority starts at bit 0.
- Combinational path: `req` → priority search → `grants`/`ptr` D inputs only. No combinational path from `req` to `grants`.

## Test plan

- Reset, then the `req` sequence below, one value per edge (N = 8). Required `grants` after each edge:
  - 10011011 → 00000001 (ptr=1)
  - 10011010 → 00000010 (ptr=2)
  - 10011000 → 00001000 (ptr=4)
  - 10011000 → 00010000 (ptr=5)
  - 10001010 → 10000000 (ptr wraps to 0)
  - 00001010 → 00000010
- Reset, then the `req` sequence 10011010, 10011000, 10011000, 10001010, 00001010 → required `grants`: 00000010, 00001000, 00010000, 10000000, 00000010.
- Reset, `req` = 11111111 held 9 edges → `grants` = 00000001, 00000010, 00000100, …, 10000000, then 00000001 again.
- `req` = 0 for 3 edges between grants → `grants` = 00000000, and the next grant continues from the unchanged ptr. Example: ptr=3, `req` = 00000011 → `grants` = 00000001.
- Single requester, `req` = 00100000 held 4 edges → `grants` = 00100000 every cycle.
- Reset mid-stream (ptr=5, `req` = 11111111, `rst` = 0 for one edge) → `grants` = 0. On the next edge with `rst` = 1 → `grants` = 00000001.
